cell_stream_link_model: RTL and testbench
=========================================

# cell_stream_link_model

Parametrised simulation model of the cell-controller CCW/CW serial links, the successor to the plain wire-through loopback. Each of CHANNELS AXI Stream channels (tvalid/tlast/tdata, no tready) is looped TX→RX through a fixed-latency pipeline, with per-channel link-up gating, packet drop and last-word corruption injection, and packet/drop counters. It sits in the testbench between the cell-controller TX and RX stream ports.

## Interface
- CHANNELS, 2, number of independent links (channel 0 = CCW, 1 = CW)
- DATA_WIDTH, 32, tdata width per channel
- LATENCY, 4, TX-to-RX delay in clock cycles; legal range 1..64
- COUNT_WIDTH, 16, width of each packet counter
- auroraUserClk  input  1  sole clock; all logic on rising edge
- auroraReset  input  1  synchronous, active-high reset
- tx_tdata  input  CHANNELS*DATA_WIDTH  TX data; channel n at [n*DATA_WIDTH +: DATA_WIDTH]
- tx_tlast  input  CHANNELS  TX end-of-packet
- tx_tvalid  input  CHANNELS  TX word valid
- rx_tdata  output  CHANNELS*DATA_WIDTH  RX data, same packing
- rx_tlast  output  CHANNELS  RX end-of-packet
- rx_tvalid  output  CHANNELS  RX word valid
- linkUp  input  CHANNELS  per-channel link status; 0 drops packets
- dropStrobe  input  CHANNELS  one-cycle request: drop next packet
- corruptStrobe  input  CHANNELS  one-cycle request: corrupt next forwarded packet
- corruptMask  input  CHANNELS*DATA_WIDTH  XOR mask applied to corrupted word
- packetCount  output  CHANNELS*COUNT_WIDTH  packets forwarded, per channel
- dropCount  output  CHANNELS*COUNT_WIDTH  packets dropped, per channel

## Operation
- Channels fully independent; no cross-channel interaction.
- Packet = words from first tvalid after reset or after a tlast word, through the next tvalid&tlast word inclusive. tvalid low cycles inside a packet are gaps, preserved in the output.
- Per-channel state: IDLE (between packets), PASS, DROP.
- IDLE, tvalid=1: decide on this word. Drop if linkUp=0 or dropPending or dropStrobe this cycle. Otherwise pass. If the word has tlast, stay IDLE (single-word packet); else go PASS or DROP.
- PASS/DROP, tvalid&tlast → IDLE. Decision never changes mid-packet; linkUp changes mid-packet take effect at the next packet.
- Passed words enter the delay line. Dropped words enter as tvalid=0.
- dropPending set by dropStrobe, cleared when a packet is dropped for any reason, including linkUp=0.
- corruptPending set by corruptStrobe, cleared on the tlast word of the next passed packet. That word's tdata is XORed with corruptMask sampled on that same cycle.
- A strobe coincident with a packet's first word applies to that packet. A strobe during a packet applies to the next one.
- Drop and corrupt both pending: drop wins; corruptPending carries to the next passed packet.
- packetCount increments on each passed tlast word; dropCount on each dropped tlast word. Both wrap modulo 2^COUNT_WIDTH.

## Timing
- Input registered, then LATENCY-1 further stages. rx word at cycle t+LATENCY equals (possibly corrupted) tx word at cycle t.
- LATENCY=1: one register, no gaps added or removed.
- Counters update the cycle after the tlast word is accepted at the input, not at output.
- Reset: rx_tvalid=0, rx_tlast=0, rx_tdata=0.
- Reset also clears all delay-line stages, clears both pending flags and both counters, and returns state to IDLE.
- Reset mid-packet: in-flight words lost. The first tvalid after reset starts a new packet, even if the pre-reset packet had no tlast.
- tdata of stages with tvalid=0 is don't-care internally but driven 0 at rx outputs (masked).

## Structure
- Shared header: state encodings (IDLE/PASS/DROP) and the LATENCY range-check macro. Elaboration fails for LATENCY outside 1..64.
- One sub-module, cell_stream_link_channel: one channel's state machine, pending flags, counters and delay line. Generated CHANNELS times; the top level only slices the packed buses.

## Test plan
- LATENCY=4, linkUp=1, 3-word packet 0x11,0x22,0x33 (tlast on 0x33) on ch0 → same words at rx ch0 exactly 4 cycles later with gaps preserved; packetCount[0]=1; ch1 idle.
- dropStrobe on ch1, then packets A and B → A absent at rx, B forwarded; dropCount[1]=1, packetCount[1]=1.
- corruptStrobe with mask 0x0000_00FF, packet ending 0x1234_5678 → last word at rx = 0x1234_5687; earlier words unchanged; next packet clean.
- Drop and corrupt strobed together, then two packets → first dropped, second's last word corrupted.
- linkUp deasserted mid-packet, reasserted before the next packet → current packet fully forwarded, next forwarded. linkUp=0 at a first word → whole packet dropped.
- auroraReset during a packet with 4 words in flight → rx_tvalid=0 from the reset cycle onward, counters 0. A new packet after reset passes normally, with packetCount=1 after its tlast.

Source files
------------

// File: rtl/cell_stream_link_model_pkg.sv
// cell_stream_link_model_pkg: shared state encoding and LATENCY legality check
// Ports: none (package)
package cell_stream_link_model_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_DROP} state_e;
   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 64;
   function automatic bit latency_ok(input int l);
      return (l >= LATENCY_MIN) && (l <= LATENCY_MAX);
   endfunction
endpackage

// File: rtl/cell_stream_link_channel.sv
// cell_stream_link_channel: one looped link with packet FSM, drop/corrupt injection, counters and delay line
// Ports: i_clk/i_rst clock and sync reset; i_tvalid/i_tlast/i_tdata TX word; i_link_up link status;
//        i_drop_strobe/i_corrupt_strobe/i_corrupt_mask fault injection; o_tvalid/o_tlast/o_tdata RX word;
//        o_packet_count/o_drop_count forwarded and dropped packet counters
module cell_stream_link_channel
   import cell_stream_link_model_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int LATENCY     = 4,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_tvalid,
   input  logic                   i_tlast,
   input  logic [DATA_WIDTH-1:0]  i_tdata,
   input  logic                   i_link_up,
   input  logic                   i_drop_strobe,
   input  logic                   i_corrupt_strobe,
   input  logic [DATA_WIDTH-1:0]  i_corrupt_mask,
   output logic                   o_tvalid,
   output logic                   o_tlast,
   output logic [DATA_WIDTH-1:0]  o_tdata,
   output logic [COUNT_WIDTH-1:0] o_packet_count,
   output logic [COUNT_WIDTH-1:0] o_drop_count
);
   state_e                 r_state, w_next_state;
   logic                   r_drop_pending, r_corrupt_pending, r_corrupt_cur;
   logic [COUNT_WIDTH-1:0] r_packet_count, r_drop_count;
   logic                   r_v [LATENCY];
   logic                   r_l [LATENCY];
   logic [DATA_WIDTH-1:0]  r_d [LATENCY];
   logic                   w_first, w_drop_now, w_pass_word, w_drop_word, w_corrupt_word;
   logic                   w_next_drop_pending, w_next_corrupt_pending, w_next_corrupt_cur;
   logic [DATA_WIDTH-1:0]  w_in_d;
   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= ST_IDLE;
      else r_state <= w_next_state;
   end
   always_comb begin
      w_next_state = r_state;
      if (i_tvalid)
         w_next_state = (r_state == ST_IDLE) ? (i_tlast ? ST_IDLE : (w_drop_now ? ST_DROP : ST_PASS))
                                             : (i_tlast ? ST_IDLE : r_state);
   end
   // The pass/drop decision is taken only on a packet's first word; later words follow the latched state.
   always_comb begin
      w_first                = i_tvalid & (r_state == ST_IDLE);
      w_drop_now             = ~i_link_up | r_drop_pending | i_drop_strobe;
      w_pass_word            = i_tvalid & (w_first ? ~w_drop_now : (r_state == ST_PASS));
      w_drop_word            = i_tvalid & ~w_pass_word;
      w_corrupt_word         = w_pass_word & i_tlast & (w_first ? (r_corrupt_pending | i_corrupt_strobe) : r_corrupt_cur);
      w_next_drop_pending    = (w_first & w_drop_now) ? 1'b0 : (r_drop_pending | i_drop_strobe);
      // A pending corruption is bound to a packet when it is accepted, so strobes arriving mid-packet
      // remain pending for the following one. Dropped packets leave it pending.
      w_next_corrupt_pending = (w_first & ~w_drop_now) ? 1'b0 : (r_corrupt_pending | i_corrupt_strobe);
      w_next_corrupt_cur     = (w_first & ~w_drop_now) ? (r_corrupt_pending | i_corrupt_strobe) : r_corrupt_cur;
      w_in_d                 = i_tdata ^ (w_corrupt_word ? i_corrupt_mask : '0);
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_drop_pending    <= 1'b0;
         r_corrupt_pending <= 1'b0;
         r_corrupt_cur     <= 1'b0;
         r_packet_count    <= '0;
         r_drop_count      <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            r_v[i] <= 1'b0;
            r_l[i] <= 1'b0;
            r_d[i] <= '0;
         end
      end else begin
         r_drop_pending    <= w_next_drop_pending;
         r_corrupt_pending <= w_next_corrupt_pending;
         r_corrupt_cur     <= w_next_corrupt_cur;
         if (w_pass_word & i_tlast) r_packet_count <= r_packet_count + COUNT_WIDTH'(1);
         if (w_drop_word & i_tlast) r_drop_count <= r_drop_count + COUNT_WIDTH'(1);
         r_v[0] <= w_pass_word;
         r_l[0] <= w_pass_word & i_tlast;
         r_d[0] <= w_in_d;
         for (int i = 1; i < LATENCY; i++) begin
            r_v[i] <= r_v[i-1];
            r_l[i] <= r_l[i-1];
            r_d[i] <= r_d[i-1];
         end
      end
   end
   assign o_tvalid       = r_v[LATENCY-1];
   assign o_tlast        = r_v[LATENCY-1] & r_l[LATENCY-1];
   assign o_tdata        = r_v[LATENCY-1] ? r_d[LATENCY-1] : '0;
   assign o_packet_count = r_packet_count;
   assign o_drop_count   = r_drop_count;
endmodule

// File: rtl/cell_stream_link_model.sv
// cell_stream_link_model: CHANNELS independent TX-to-RX stream loopbacks with fault injection
// Ports: auroraUserClk/auroraReset clock and sync reset; tx_* packed TX streams; rx_* packed RX streams;
//        linkUp/dropStrobe/corruptStrobe/corruptMask per-channel controls; packetCount/dropCount counters
module cell_stream_link_model
   import cell_stream_link_model_pkg::*;
#(
   parameter int CHANNELS    = 2,
   parameter int DATA_WIDTH  = 32,
   parameter int LATENCY     = 4,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                            auroraUserClk,
   input  logic                            auroraReset,
   input  logic [CHANNELS*DATA_WIDTH-1:0]  tx_tdata,
   input  logic [CHANNELS-1:0]             tx_tlast,
   input  logic [CHANNELS-1:0]             tx_tvalid,
   output logic [CHANNELS*DATA_WIDTH-1:0]  rx_tdata,
   output logic [CHANNELS-1:0]             rx_tlast,
   output logic [CHANNELS-1:0]             rx_tvalid,
   input  logic [CHANNELS-1:0]             linkUp,
   input  logic [CHANNELS-1:0]             dropStrobe,
   input  logic [CHANNELS-1:0]             corruptStrobe,
   input  logic [CHANNELS*DATA_WIDTH-1:0]  corruptMask,
   output logic [CHANNELS*COUNT_WIDTH-1:0] packetCount,
   output logic [CHANNELS*COUNT_WIDTH-1:0] dropCount
);
   if (!latency_ok(LATENCY)) begin : g_latency_check
      $fatal(1, "cell_stream_link_model: LATENCY must be within 1..64");
   end
   for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
      cell_stream_link_channel #(
         .DATA_WIDTH  (DATA_WIDTH),
         .LATENCY     (LATENCY),
         .COUNT_WIDTH (COUNT_WIDTH)
      ) u_channel (
         .i_clk            (auroraUserClk),
         .i_rst            (auroraReset),
         .i_tvalid         (tx_tvalid[n]),
         .i_tlast          (tx_tlast[n]),
         .i_tdata          (tx_tdata[n*DATA_WIDTH +: DATA_WIDTH]),
         .i_link_up        (linkUp[n]),
         .i_drop_strobe    (dropStrobe[n]),
         .i_corrupt_strobe (corruptStrobe[n]),
         .i_corrupt_mask   (corruptMask[n*DATA_WIDTH +: DATA_WIDTH]),
         .o_tvalid         (rx_tvalid[n]),
         .o_tlast          (rx_tlast[n]),
         .o_tdata          (rx_tdata[n*DATA_WIDTH +: DATA_WIDTH]),
         .o_packet_count   (packetCount[n*COUNT_WIDTH +: COUNT_WIDTH]),
         .o_drop_count     (dropCount[n*COUNT_WIDTH +: COUNT_WIDTH])
      );
   end
endmodule

// File: tb/tb_cell_stream_link_model.sv
// tb_cell_stream_link_model: directed and random stimulus against a packet-level reference model
module tb_cell_stream_link_model;
   localparam int CH = 2, DW = 32, LAT = 4, CW = 16, DEPTH = 4096;
   logic             clk = 1'b0;
   logic             rst;
   logic [CH*DW-1:0] tx_tdata, rx_tdata, corrupt_mask;
   logic [CH-1:0]    tx_tlast, tx_tvalid, rx_tlast, rx_tvalid, link_up, drop_strobe, corrupt_strobe;
   logic [CH*CW-1:0] packet_count, drop_count;
   int tests = 0, fails = 0, cyc = 0;
   bit          exp_v [CH][DEPTH];
   bit          exp_l [CH][DEPTH];
   bit [DW-1:0] exp_d [CH][DEPTH];
   bit in_pkt [CH], pkt_drop [CH], pkt_corr [CH], drop_pend [CH], corr_pend [CH];
   int pcnt [CH], dcnt [CH];
   always #5 clk = ~clk;
   cell_stream_link_model #(.CHANNELS(CH), .DATA_WIDTH(DW), .LATENCY(LAT), .COUNT_WIDTH(CW)) dut (
      .auroraUserClk (clk),
      .auroraReset   (rst),
      .tx_tdata      (tx_tdata),
      .tx_tlast      (tx_tlast),
      .tx_tvalid     (tx_tvalid),
      .rx_tdata      (rx_tdata),
      .rx_tlast      (rx_tlast),
      .rx_tvalid     (rx_tvalid),
      .linkUp        (link_up),
      .dropStrobe    (drop_strobe),
      .corruptStrobe (corrupt_strobe),
      .corruptMask   (corrupt_mask),
      .packetCount   (packet_count),
      .dropCount     (drop_count)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, got, want);
      end
   endtask
   // Reference: each packet is classified once when its first word shows up; the rx stream is the
   // tx stream of LAT cycles earlier with dropped packets blanked and corruption on the chosen last word.
   task automatic model_cycle();
      bit v, l, ds, cs, lk, fwd;
      bit [DW-1:0] d, m;
      int idx;
      for (int c = 0; c < CH; c++) begin
         v  = tx_tvalid[c];
         l  = tx_tlast[c];
         d  = tx_tdata[c*DW +: DW];
         m  = corrupt_mask[c*DW +: DW];
         ds = drop_strobe[c];
         cs = corrupt_strobe[c];
         lk = link_up[c];
         if (v && !in_pkt[c]) begin
            pkt_drop[c] = !lk || drop_pend[c] || ds;
            if (pkt_drop[c]) begin
               drop_pend[c] = 0;
               corr_pend[c] = corr_pend[c] || cs;
            end else begin
               pkt_corr[c]  = corr_pend[c] || cs;
               corr_pend[c] = 0;
            end
         end else begin
            drop_pend[c] = drop_pend[c] || ds;
            corr_pend[c] = corr_pend[c] || cs;
         end
         fwd = v && !pkt_drop[c];
         idx = (cyc + LAT) % DEPTH;
         exp_v[c][idx] = fwd;
         exp_l[c][idx] = fwd && l;
         exp_d[c][idx] = fwd ? (d ^ ((l && pkt_corr[c]) ? m : '0)) : '0;
         if (v && l) begin
            if (pkt_drop[c]) dcnt[c] = (dcnt[c] + 1) % 65536;
            else pcnt[c] = (pcnt[c] + 1) % 65536;
         end
         if (v) in_pkt[c] = !l;
      end
   endtask
   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         in_pkt[c] = 0; drop_pend[c] = 0; corr_pend[c] = 0; pkt_drop[c] = 0; pkt_corr[c] = 0;
         pcnt[c] = 0; dcnt[c] = 0;
         for (int k = 1; k <= LAT; k++) begin
            exp_v[c][(cyc+k)%DEPTH] = 0;
            exp_l[c][(cyc+k)%DEPTH] = 0;
            exp_d[c][(cyc+k)%DEPTH] = '0;
         end
      end
   endtask
   task automatic tick();
      if (rst) model_reset();
      else model_cycle();
      @(posedge clk);
      #1;
      cyc++;
      for (int c = 0; c < CH; c++) begin
         check($sformatf("rx_tvalid[%0d]", c), 64'(rx_tvalid[c]), 64'(exp_v[c][cyc%DEPTH]));
         check($sformatf("rx_tlast[%0d]", c), 64'(rx_tlast[c]), 64'(exp_l[c][cyc%DEPTH]));
         check($sformatf("rx_tdata[%0d]", c), 64'(rx_tdata[c*DW +: DW]), 64'(exp_d[c][cyc%DEPTH]));
         check($sformatf("packetCount[%0d]", c), 64'(packet_count[c*CW +: CW]), 64'(pcnt[c]));
         check($sformatf("dropCount[%0d]", c), 64'(drop_count[c*CW +: CW]), 64'(dcnt[c]));
      end
      tx_tvalid = '0; tx_tlast = '0; drop_strobe = '0; corrupt_strobe = '0; rst = 1'b0;
   endtask
   task automatic word(input int c, input bit l, input logic [DW-1:0] d);
      tx_tvalid[c] = 1'b1;
      tx_tlast[c]  = l;
      tx_tdata[c*DW +: DW] = d;
      tick();
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask
   initial begin
      rst = 1'b1; tx_tdata = '0; tx_tlast = '0; tx_tvalid = '0; link_up = '1;
      drop_strobe = '0; corrupt_strobe = '0; corrupt_mask = '0;
      tick(); rst = 1'b1; tick(); idle(2);
      // plain 3-word packet with a gap on ch0
      word(0, 0, 32'h11); tick(); word(0, 0, 32'h22); word(0, 1, 32'h33); idle(LAT+1);
      check("plan_pkt_ch0", 64'(packet_count[CW-1:0]), 64'd1);
      check("plan_idle_ch1", 64'(packet_count[2*CW-1:CW]), 64'd0);
      // drop strobe on ch1 then packets A and B
      drop_strobe[1] = 1'b1; tick();
      word(1, 0, 32'hA0); word(1, 1, 32'hA1); word(1, 0, 32'hB0); word(1, 1, 32'hB1); idle(LAT+1);
      check("plan_drop_ch1", 64'(drop_count[2*CW-1:CW]), 64'd1);
      check("plan_pass_ch1", 64'(packet_count[2*CW-1:CW]), 64'd1);
      // corrupt last word, next packet clean
      corrupt_mask[DW-1:0] = 32'h0000_00FF; corrupt_strobe[0] = 1'b1; tick();
      word(0, 0, 32'hAAAA_0001); word(0, 1, 32'h1234_5678); idle(LAT-1);
      check("plan_corrupt_word", 64'(rx_tdata[DW-1:0]), 64'h1234_5687);
      word(0, 0, 32'h5555_0000); word(0, 1, 32'h1234_5678); idle(LAT+1);
      // drop and corrupt together: first dropped, second corrupted
      drop_strobe[0] = 1'b1; corrupt_strobe[0] = 1'b1; tick();
      word(0, 0, 32'hC0); word(0, 1, 32'hC1); word(0, 0, 32'hD0); word(0, 1, 32'hD1); idle(LAT+1);
      // strobe coincident with a first word, and strobe mid-packet
      drop_strobe[1] = 1'b1; word(1, 1, 32'hE0);
      word(1, 0, 32'hE1); corrupt_strobe[1] = 1'b1; corrupt_mask[2*DW-1:DW] = 32'hF0F0_0000;
      word(1, 1, 32'hE2); word(1, 1, 32'hE3); idle(LAT+1);
      // linkUp drops mid-packet, then at a first word
      word(1, 0, 32'h100); link_up[1] = 1'b0; word(1, 0, 32'h101); word(1, 1, 32'h102);
      link_up[1] = 1'b1; word(1, 1, 32'h103);
      link_up[1] = 1'b0; word(1, 0, 32'h200); link_up[1] = 1'b1; word(1, 1, 32'h201); idle(LAT+1);
      // reset with words in flight
      word(0, 0, 32'h300); word(0, 0, 32'h301); word(0, 0, 32'h302); word(0, 0, 32'h303);
      rst = 1'b1; tx_tvalid[0] = 1'b1; tx_tdata[DW-1:0] = 32'h304; tick();
      check("plan_rst_pkt", 64'(packet_count), 64'd0);
      check("plan_rst_drop", 64'(drop_count), 64'd0);
      idle(LAT);
      word(0, 0, 32'h400); word(0, 1, 32'h401); idle(LAT+1);
      check("plan_after_rst", 64'(packet_count[CW-1:0]), 64'd1);
      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         for (int c = 0; c < CH; c++) begin
            tx_tvalid[c]      = ($urandom_range(0, 9) < 6);
            tx_tlast[c]       = ($urandom_range(0, 9) < 3);
            tx_tdata[c*DW +: DW]     = $urandom;
            corrupt_mask[c*DW +: DW] = $urandom;
            link_up[c]        = ($urandom_range(0, 9) != 0);
            drop_strobe[c]    = ($urandom_range(0, 14) == 0);
            corrupt_strobe[c] = ($urandom_range(0, 9) == 0);
         end
         rst = ($urandom_range(0, 249) == 0);
         tick();
      end
      link_up = '1;
      idle(LAT+2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
